// File: rtl/axis_frame_packetizer_pkg.sv
// Shared types and default geometry for the pixel pipeline.
// Holds image size defaults, packetizer FSM encoding and sideband layout.
package axis_frame_packetizer_pkg;

   localparam int IMG_WIDTH  = 512;
   localparam int IMG_HEIGHT = 512;

   typedef enum logic {
      SOF  = 1'b0,
      BODY = 1'b1
   } pkt_state_t;

   // Sideband carried next to each pixel through the skid buffer.
   typedef struct packed {
      logic tlast;
      logic tuser;
   } sband_t;

   localparam int SB_W = $bits(sband_t);

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready skid buffer (output register + skid register).
// Ports: in_* upstream beat, out_* downstream beat; in_ready is registered.
module axis_skid_buffer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   logic         out_v_q;
   logic         out_v_d;
   logic [W-1:0] out_q;
   logic [W-1:0] out_d;
   logic         skid_v_q;
   logic         skid_v_d;
   logic [W-1:0] skid_q;
   logic [W-1:0] skid_d;
   logic         rdy_q;
   logic         in_beat;
   logic         load;

   assign in_beat   = in_valid & rdy_q;
   // Output register can take a new beat when empty or draining.
   assign load      = ~out_v_q | out_ready;
   assign in_ready  = rdy_q;
   assign out_valid = out_v_q;
   assign out_data  = out_q;

   always_comb begin
      out_v_d  = out_v_q;
      out_d    = out_q;
      skid_v_d = skid_v_q;
      skid_d   = skid_q;
      unique case (1'b1)
         (load && skid_v_q): begin
            // in_ready is low while skid is full, so no
            // input beat can arrive here.
            out_v_d  = 1'b1;
            out_d    = skid_q;
            skid_v_d = 1'b0;
         end
         (load && !skid_v_q): begin
            out_v_d = in_beat;
            if (in_beat) out_d = in_data;
         end
         (!load): begin
            if (in_beat) begin
               skid_v_d = 1'b1;
               skid_d   = in_data;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_v_q  <= 1'b0;
         out_q    <= '0;
         skid_v_q <= 1'b0;
         skid_q   <= '0;
         rdy_q    <= 1'b0;
      end else begin
         out_v_q  <= out_v_d;
         out_q    <= out_d;
         skid_v_q <= skid_v_d;
         skid_q   <= skid_d;
         rdy_q    <= ~skid_v_d;
      end
   end

endmodule

// File: rtl/axis_frame_packetizer.sv
// Adds AXI4-Stream framing (tuser=SOF, tlast=EOF) to a pixel stream,
// with frame-done pulse and frame counter. Ports: s_axis_* in, m_axis_* out,
// o_frame_done, o_frame_count. Macro LINE_TLAST_EN: tlast per line + o_line_done.
module axis_frame_packetizer #(
   parameter int IMG_WIDTH  = axis_frame_packetizer_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT = axis_frame_packetizer_pkg::IMG_HEIGHT,
   parameter int DATA_W     = 8,
   parameter int CNT_W      = 16
) (
   input  logic              axi_clk,
   input  logic              axi_reset_n,
   input  logic              s_axis_tvalid,
   input  logic [DATA_W-1:0] s_axis_tdata,
   output logic              s_axis_tready,
   output logic              m_axis_tvalid,
   output logic [DATA_W-1:0] m_axis_tdata,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
`ifdef LINE_TLAST_EN
   output logic              o_line_done,
`endif
   output logic              o_frame_done,
   output logic [CNT_W-1:0]  o_frame_count
);

   import axis_frame_packetizer_pkg::*;

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W =
      (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int PW = DATA_W + SB_W;
   localparam logic [COL_W-1:0] COL_LAST =
      COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST =
      ROW_W'(IMG_HEIGHT - 1);

   pkt_state_t        state_q;
   pkt_state_t        state_d;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic              in_beat;
   logic              out_beat;
   logic              end_col;
   logic              end_frame;
   logic              frame_end_out;
   sband_t            sb_in;
   sband_t            sb_out;
   logic [PW-1:0]     pl_in;
   logic [PW-1:0]     pl_out;
   logic              done_q;
   logic [CNT_W-1:0]  cnt_q;

   assign in_beat   = s_axis_tvalid & s_axis_tready;
   assign out_beat  = m_axis_tvalid & m_axis_tready;
   assign end_col   = (col_q == COL_LAST);
   assign end_frame = end_col & (row_q == ROW_LAST);

   // Framing is computed when the beat is accepted and
   // rides through the skid buffer with its pixel.
   always_comb begin
      state_d     = state_q;
      sb_in       = '0;
      sb_in.tuser = (state_q == SOF);
`ifdef LINE_TLAST_EN
      sb_in.tlast = end_col;
`else
      sb_in.tlast = end_frame;
`endif
      unique case (state_q)
         SOF: begin
            if (in_beat && !end_frame) state_d = BODY;
         end
         BODY: begin
            if (in_beat && end_frame) state_d = SOF;
         end
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state_q <= SOF;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         col_q <= '0;
         row_q <= '0;
      end else if (in_beat) begin
         if (end_col) begin
            col_q <= '0;
            row_q <= end_frame ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   assign pl_in = {sb_in, s_axis_tdata};

   axis_skid_buffer #(
      .W (PW)
   ) u_skid (
      .clk       (axi_clk),
      .rst_n     (axi_reset_n),
      .in_valid  (s_axis_tvalid),
      .in_data   (pl_in),
      .in_ready  (s_axis_tready),
      .out_valid (m_axis_tvalid),
      .out_data  (pl_out),
      .out_ready (m_axis_tready)
   );

   assign sb_out       = sband_t'(pl_out[PW-1:DATA_W]);
   assign m_axis_tdata = pl_out[DATA_W-1:0];
   assign m_axis_tlast = sb_out.tlast;
   assign m_axis_tuser = sb_out.tuser;

`ifdef LINE_TLAST_EN
   // tlast marks every line here, so count output lines
   // to find the one that closes the frame.
   logic [ROW_W-1:0] out_row_q;
   logic             line_q;

   assign frame_end_out =
      out_beat & sb_out.tlast & (out_row_q == ROW_LAST);

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         out_row_q <= '0;
         line_q    <= 1'b0;
      end else begin
         line_q <= out_beat & sb_out.tlast;
         if (out_beat && sb_out.tlast) begin
            out_row_q <= (out_row_q == ROW_LAST) ?
                         '0 : out_row_q + 1'b1;
         end
      end
   end

   assign o_line_done = line_q;
`else
   assign frame_end_out = out_beat & sb_out.tlast;
`endif

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         done_q <= frame_end_out;
         if (frame_end_out) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign o_frame_done  = done_q;
   assign o_frame_count = cnt_q;

endmodule

// File: tb/tb_axis_frame_packetizer.sv
// Self-checking bench for axis_frame_packetizer (W=4, H=2, CNT_W=2).
// Directed table, stall/reset sequences, and random traffic vs. a queue model.
module tb_axis_frame_packetizer;

   localparam int W = 4;
   localparam int H = 2;
   localparam int F = W * H;
`ifdef LINE_TLAST_EN
   localparam bit LINE = 1'b1;
`else
   localparam bit LINE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_tvalid = 1'b0;
   logic [7:0] s_tdata = '0;
   logic       s_tready;
   logic       m_tvalid;
   logic [7:0] m_tdata;
   logic       m_tready = 1'b0;
   logic       m_tlast;
   logic       m_tuser;
   logic       fdone;
   logic [1:0] fcnt;
`ifdef LINE_TLAST_EN
   logic       ldone;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   axis_frame_packetizer #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .DATA_W     (8),
      .CNT_W      (2)
   ) dut (
      .axi_clk       (clk),
      .axi_reset_n   (rst_n),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tdata  (s_tdata),
      .s_axis_tready (s_tready),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tdata  (m_tdata),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
`ifdef LINE_TLAST_EN
      .o_line_done   (ldone),
`endif
      .o_frame_done  (fdone),
      .o_frame_count (fcnt)
   );

   task automatic chk(input string name, input int act,
                      input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted beat's framing follows
   // from its index since reset; beats leave in order.
   typedef struct {
      logic [7:0] dat;
      bit         usr;
      bit         lst;
      bit         fend;
      bit         lend;
   } beat_t;

   beat_t      q[$];
   int         n_in;
   bit         exp_fd;
   bit         exp_ld;
   logic [1:0] exp_cnt;
   bit         stall_prev;
   logic [7:0] prev_dat;
   bit         prev_usr;
   bit         prev_lst;

   task automatic model_reset();
      q.delete();
      n_in       = 0;
      exp_fd     = 1'b0;
      exp_ld     = 1'b0;
      exp_cnt    = 2'd0;
      stall_prev = 1'b0;
   endtask

   task automatic do_reset(input bit check_zero);
      s_tvalid = 1'b0;
      s_tdata  = '0;
      m_tready = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (check_zero) begin
         chk("rst_s_tready", int'(s_tready), 0);
         chk("rst_m_tvalid", int'(m_tvalid), 0);
         chk("rst_m_tdata", int'(m_tdata), 0);
         chk("rst_m_tlast", int'(m_tlast), 0);
         chk("rst_m_tuser", int'(m_tuser), 0);
         chk("rst_fdone", int'(fdone), 0);
         chk("rst_fcnt", int'(fcnt), 0);
`ifdef LINE_TLAST_EN
         chk("rst_ldone", int'(ldone), 0);
`endif
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic run_random(input int cycles);
      beat_t b;
      beat_t e;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         chk("rnd_s_tready", int'(s_tready),
             int'(q.size() < 2));
         chk("rnd_m_tvalid", int'(m_tvalid),
             int'(q.size() > 0));
         if (m_tvalid && q.size() > 0) begin
            chk("rnd_tdata", int'(m_tdata), int'(q[0].dat));
            chk("rnd_tuser", int'(m_tuser), int'(q[0].usr));
            chk("rnd_tlast", int'(m_tlast), int'(q[0].lst));
         end
         chk("rnd_fdone", int'(fdone), int'(exp_fd));
         chk("rnd_fcnt", int'(fcnt), int'(exp_cnt));
`ifdef LINE_TLAST_EN
         chk("rnd_ldone", int'(ldone), int'(exp_ld));
`endif
         if (stall_prev) begin
            chk("stall_tvalid", int'(m_tvalid), 1);
            chk("stall_tdata", int'(m_tdata), int'(prev_dat));
            chk("stall_tuser", int'(m_tuser), int'(prev_usr));
            chk("stall_tlast", int'(m_tlast), int'(prev_lst));
         end
         s_tvalid = ($urandom_range(0, 3) != 0);
         s_tdata  = 8'($urandom);
         m_tready = ($urandom_range(0, 2) != 0);
         stall_prev = m_tvalid & ~m_tready;
         prev_dat   = m_tdata;
         prev_usr   = m_tuser;
         prev_lst   = m_tlast;
         exp_fd = 1'b0;
         exp_ld = 1'b0;
         if (s_tvalid && s_tready) begin
            b.dat  = s_tdata;
            b.usr  = (n_in % F) == 0;
            b.fend = (n_in % F) == F - 1;
            b.lend = (n_in % W) == W - 1;
            b.lst  = LINE ? b.lend : b.fend;
            q.push_back(b);
            n_in++;
         end
         if (m_tvalid && m_tready && q.size() > 0) begin
            e = q.pop_front();
            if (e.fend) begin
               exp_fd  = 1'b1;
               exp_cnt = exp_cnt + 2'd1;
            end
            exp_ld = e.lst && LINE;
         end
      end
      s_tvalid = 1'b0;
   endtask

   typedef struct {
      logic       vld;
      logic [7:0] dat;
      logic       rdy;
      logic       e_vld;
      logic [7:0] e_dat;
      logic       e_usr;
      logic       e_lst;
      logic       e_fd;
      logic       e_ld;
      logic [1:0] e_cnt;
   } vec_t;

   vec_t tbl[10];

   initial begin
      for (int i = 0; i < 10; i++) begin
         tbl[i].vld   = (i < 8);
         tbl[i].dat   = 8'(i);
         tbl[i].rdy   = 1'b1;
         tbl[i].e_vld = (i < 8);
         tbl[i].e_dat = 8'(i);
         tbl[i].e_usr = (i == 0);
         tbl[i].e_lst = LINE ? (i == 3 || i == 7) : (i == 7);
         tbl[i].e_fd  = (i == 8);
         tbl[i].e_ld  = LINE && (i == 4 || i == 8);
         tbl[i].e_cnt = (i >= 8) ? 2'd1 : 2'd0;
      end

      model_reset();
      do_reset(1'b1);
      @(negedge clk);
      chk("tready_after_rst", int'(s_tready), 1);

      for (int i = 0; i < 10; i++) begin
         s_tvalid = tbl[i].vld;
         s_tdata  = tbl[i].dat;
         m_tready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_tvalid", i),
             int'(m_tvalid), int'(tbl[i].e_vld));
         if (tbl[i].e_vld) begin
            chk($sformatf("tbl%0d_tdata", i),
                int'(m_tdata), int'(tbl[i].e_dat));
            chk($sformatf("tbl%0d_tuser", i),
                int'(m_tuser), int'(tbl[i].e_usr));
            chk($sformatf("tbl%0d_tlast", i),
                int'(m_tlast), int'(tbl[i].e_lst));
         end
         chk($sformatf("tbl%0d_s_tready", i),
             int'(s_tready), 1);
         chk($sformatf("tbl%0d_fdone", i),
             int'(fdone), int'(tbl[i].e_fd));
         chk($sformatf("tbl%0d_fcnt", i),
             int'(fcnt), int'(tbl[i].e_cnt));
`ifdef LINE_TLAST_EN
         chk($sformatf("tbl%0d_ldone", i),
             int'(ldone), int'(tbl[i].e_ld));
`endif
      end

      // Skid fill and drain with the output stalled.
      s_tvalid = 1'b1;
      s_tdata  = 8'hA0;
      m_tready = 1'b0;
      @(negedge clk);
      chk("sk_first_vld", int'(m_tvalid), 1);
      chk("sk_first_dat", int'(m_tdata), 8'hA0);
      chk("sk_first_usr", int'(m_tuser), 1);
      chk("sk_first_rdy", int'(s_tready), 1);
      s_tdata = 8'hA1;
      @(negedge clk);
      chk("sk_full_rdy", int'(s_tready), 0);
      chk("sk_full_dat", int'(m_tdata), 8'hA0);
      s_tdata = 8'hA2;
      @(negedge clk);
      chk("sk_hold_rdy", int'(s_tready), 0);
      chk("sk_hold_dat", int'(m_tdata), 8'hA0);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      @(negedge clk);
      chk("sk_drain_vld", int'(m_tvalid), 1);
      chk("sk_drain_dat", int'(m_tdata), 8'hA1);
      chk("sk_drain_usr", int'(m_tuser), 0);
      chk("sk_drain_rdy", int'(s_tready), 1);
      @(negedge clk);
      chk("sk_empty_vld", int'(m_tvalid), 0);

      do_reset(1'b0);
      run_random(400);

      // Reset after five beats of a frame.
      do_reset(1'b0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'(8'h50 + i);
         m_tready = 1'b1;
         @(negedge clk);
      end
      chk("mid_tdata", int'(m_tdata), 8'h54);
      do_reset(1'b1);
      run_random(200);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
